// File: rtl/rv_write_q.sv
// rv_write_q: writeback stage with an in-order completion queue, load alignment and flushed-load discard.
// Optional macro RV_WRITE_MEM_FWD_EN forwards a head-matched memory response straight to writeback.
module rv_write_q #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 5
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_alu_result,
   input  logic [XLEN-1:0] i_alu_ext,
   input  logic            i_alu_is_ext,
   input  logic            i_reg_write,
   input  logic [4:0]      i_rd,
   input  logic [1:0]      i_res_src,
   input  logic            i_mem_valid,
   input  logic [XLEN-1:0] i_mem_data,
   output logic [XLEN-1:0] o_data,
   output logic [4:0]      o_rd,
   output logic            o_write_op,
   output logic            o_busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int LB = $clog2(XLEN / 8);
   // Result-source encoding; only the memory source marks a load.
   localparam logic [1:0] RES_SRC_MEMORY = 2'd1;

   logic [PW-1:0]     headPtr_q, headPtr_d, tailPtr_q, tailPtr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic [2:0]        funct3_q  [DEPTH];
   logic [LB-1:0]     lane_q    [DEPTH];
   logic [XLEN-1:0]   res_q     [DEPTH];
   logic [XLEN-1:0]   memData_q [DEPTH];
   logic [4:0]        rd_q      [DEPTH];
   logic [DEPTH-1:0]  regWrite_q, isLoad_q, hasData_q;

   logic              matchFound;
   logic [PW-1:0]     matchIdx;
   logic [CW-1:0]     pendCnt;
   logic [PW-1:0]     scanIdx;
   logic              respTake, respDrop;
   logic              headReady, retire, enq;
   logic [XLEN-1:0]   rawWord;
   logic [DROP_W-1:0] dropAdd;

   function automatic logic [XLEN-1:0] alignLoad(input logic [XLEN-1:0] raw,
                                                 input logic [2:0]      f3,
                                                 input logic [LB-1:0]   lane);
      logic [XLEN-1:0] bSh, hSh, wSh;
      logic [LB-1:0]   hLane, wLane;
      hLane = lane & ~LB'(1);
      wLane = lane & ~LB'(3);
      bSh   = raw >> {lane, 3'b000};
      hSh   = raw >> {hLane, 3'b000};
      wSh   = raw >> {wLane, 3'b000};
      case (f3)
         3'b000:  alignLoad = XLEN'($signed(bSh[7:0]));
         3'b001:  alignLoad = XLEN'($signed(hSh[15:0]));
         3'b010:  alignLoad = XLEN'($signed(wSh[31:0]));
         3'b100:  alignLoad = XLEN'(bSh[7:0]);
         3'b101:  alignLoad = XLEN'(hSh[15:0]);
         3'b110:  alignLoad = (XLEN == 64) ? XLEN'(wSh[31:0]) : '0;
         3'b011:  alignLoad = (XLEN == 64) ? raw : '0;
         default: alignLoad = '0;
      endcase
   endfunction

   // Find the oldest load still waiting for data and count all such loads.
   always_comb begin
      matchFound = 1'b0;
      matchIdx   = headPtr_q;
      pendCnt    = '0;
      scanIdx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scanIdx = headPtr_q + PW'(i);
         if ((CW'(i) < count_q) && isLoad_q[scanIdx] && !hasData_q[scanIdx]) begin
            pendCnt = pendCnt + CW'(1);
            if (!matchFound) begin
               matchFound = 1'b1;
               matchIdx   = scanIdx;
            end
         end
      end
   end

   always_comb begin
      respDrop = i_mem_valid && (drop_q != '0);
      respTake = i_mem_valid && (drop_q == '0) && matchFound;
      enq      = i_valid && o_ready && !i_flush;
`ifdef RV_WRITE_MEM_FWD_EN
      rawWord   = hasData_q[headPtr_q] ? memData_q[headPtr_q] : i_mem_data;
      headReady = (count_q != '0) && (!isLoad_q[headPtr_q] || hasData_q[headPtr_q] ||
                                      (respTake && (matchIdx == headPtr_q)));
`else
      rawWord   = memData_q[headPtr_q];
      headReady = (count_q != '0) && (!isLoad_q[headPtr_q] || hasData_q[headPtr_q]);
`endif
      retire     = headReady && !i_flush;
      o_write_op = retire && regWrite_q[headPtr_q];
      o_rd       = rd_q[headPtr_q];
      o_data     = isLoad_q[headPtr_q] ? alignLoad(rawWord, funct3_q[headPtr_q], lane_q[headPtr_q])
                                       : res_q[headPtr_q];
      o_ready    = (count_q != CW'(DEPTH));
      o_busy     = (count_q != '0) || (drop_q != '0);
   end

   // A response taken in the flush cycle already satisfied one pending load, so it is not re-counted.
   always_comb begin
      dropAdd   = DROP_W'(pendCnt) - DROP_W'(respTake);
      drop_d    = drop_q - DROP_W'(respDrop) + (i_flush ? dropAdd : '0);
      headPtr_d = headPtr_q + PW'(retire);
      tailPtr_d = tailPtr_q + PW'(enq);
      count_d   = count_q + CW'(enq) - CW'(retire);
      if (i_flush) begin
         headPtr_d = '0;
         tailPtr_d = '0;
         count_d   = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         headPtr_q <= '0;
         tailPtr_q <= '0;
         count_q   <= '0;
         drop_q    <= '0;
      end else begin
         headPtr_q <= headPtr_d;
         tailPtr_q <= tailPtr_d;
         count_q   <= count_d;
         drop_q    <= drop_d;
      end
   end

   // Entry payload needs no reset: occupancy is tracked entirely by count/pointers.
   always_ff @(posedge i_clk) begin
      if (enq) begin
         funct3_q[tailPtr_q]   <= i_funct3;
         lane_q[tailPtr_q]     <= i_alu_result[LB-1:0];
         res_q[tailPtr_q]      <= i_alu_is_ext ? i_alu_ext : i_alu_result;
         rd_q[tailPtr_q]       <= i_rd;
         regWrite_q[tailPtr_q] <= i_reg_write;
         isLoad_q[tailPtr_q]   <= (i_res_src == RES_SRC_MEMORY);
         hasData_q[tailPtr_q]  <= 1'b0;
      end
      if (respTake) begin
         memData_q[matchIdx] <= i_mem_data;
         hasData_q[matchIdx] <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (i_reset_n && i_mem_valid && (drop_q == '0))
         assert (matchFound);
   end
`endif

endmodule

// File: tb/tb_rv_write_q.sv
// Testbench for rv_write_q: XLEN=32 instance with a writeback scoreboard plus an XLEN=64 instance for wide loads.
// Timing expectations follow RV_WRITE_MEM_FWD_EN when it is defined.
module tb_rv_write_q;

`ifdef RV_WRITE_MEM_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif
   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_MEM = 2'd1;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wbExp_t;

   wbExp_t expQ[$];
   wbExp_t monExp;
   int     checks = 0;
   int     errors = 0;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        flush = 1'b0;
   logic        valid = 1'b0;
   logic [2:0]  funct3 = 3'b0;
   logic [31:0] alu = '0;
   logic [31:0] ext = '0;
   logic        isExt = 1'b0;
   logic        regWrite = 1'b0;
   logic [4:0]  rd = '0;
   logic [1:0]  resSrc = SRC_ALU;
   logic        memValid = 1'b0;
   logic [31:0] memData = '0;
   logic        ready, writeOp, busy;
   logic [31:0] data;
   logic [4:0]  rdOut;

   logic        valid64 = 1'b0;
   logic [63:0] alu64 = '0;
   logic [63:0] ext64 = '0;
   logic        memValid64 = 1'b0;
   logic [63:0] memData64 = '0;
   logic        ready64, writeOp64, busy64;
   logic [63:0] data64;
   logic [4:0]  rdOut64;

   always #5 clk = ~clk;

   rv_write_q #(.XLEN(32), .DEPTH(4), .DROP_W(5)) dut (
      .i_clk(clk), .i_reset_n(rstN), .i_flush(flush), .i_valid(valid), .o_ready(ready),
      .i_funct3(funct3), .i_alu_result(alu), .i_alu_ext(ext), .i_alu_is_ext(isExt),
      .i_reg_write(regWrite), .i_rd(rd), .i_res_src(resSrc), .i_mem_valid(memValid),
      .i_mem_data(memData), .o_data(data), .o_rd(rdOut), .o_write_op(writeOp), .o_busy(busy)
   );

   rv_write_q #(.XLEN(64), .DEPTH(4), .DROP_W(5)) dut64 (
      .i_clk(clk), .i_reset_n(rstN), .i_flush(flush), .i_valid(valid64), .o_ready(ready64),
      .i_funct3(funct3), .i_alu_result(alu64), .i_alu_ext(ext64), .i_alu_is_ext(isExt),
      .i_reg_write(regWrite), .i_rd(rd), .i_res_src(resSrc), .i_mem_valid(memValid64),
      .i_mem_data(memData64), .o_data(data64), .o_rd(rdOut64), .o_write_op(writeOp64), .o_busy(busy64)
   );

   // Every register-file write from the 32-bit instance must match the oldest expected writeback.
   always @(negedge clk) begin
      if (rstN && writeOp) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL wb_unexpected: got rd=%0d data=%h, expected no write", rdOut, data);
         end else begin
            monExp = expQ.pop_front();
            if (rdOut !== monExp.rd || data !== monExp.data) begin
               errors++;
               $display("[TB] FAIL wb_data: got rd=%0d data=%h, expected rd=%0d data=%h",
                        rdOut, data, monExp.rd, monExp.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic setAlu(input logic [4:0] r, input logic [31:0] a, input logic [31:0] e,
                         input logic useExt, input logic rw);
      valid    = 1'b1;
      resSrc   = SRC_ALU;
      alu      = a;
      ext      = e;
      isExt    = useExt;
      regWrite = rw;
      rd       = r;
      funct3   = 3'b000;
   endtask

   task automatic setLoad(input logic [4:0] r, input logic [2:0] f3, input logic [31:0] addr);
      valid    = 1'b1;
      resSrc   = SRC_MEM;
      alu      = addr;
      isExt    = 1'b0;
      regWrite = 1'b1;
      rd       = r;
      funct3   = f3;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      cycle();
      cycle();
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, expected 1", ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
      checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL reset_wop: got %b, expected 0", writeOp); end
      checks++; if (ready64 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready64: got %b, expected 1", ready64); end
      cycle();
      rstN = 1'b1;
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [4:0]  rdT [4];
      logic [31:0] aluT [4];
      logic [31:0] extT [4];
      logic        isExtT [4];
      logic        rwT [4];
      rdT = '{5'd1, 5'd2, 5'd3, 5'd4};
      aluT = '{32'h11, 32'hDEAD, 32'h33, 32'h44};
      extT = '{32'h0, 32'h22, 32'h0, 32'h0};
      isExtT = '{1'b0, 1'b1, 1'b0, 1'b0};
      rwT = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++)
         if (rwT[i]) expQ.push_back('{rd: rdT[i], data: isExtT[i] ? extT[i] : aluT[i]});
      setAlu(rdT[0], aluT[0], extT[0], isExtT[0], rwT[0]);
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (i < 3) setAlu(rdT[i+1], aluT[i+1], extT[i+1], isExtT[i+1], rwT[i+1]);
         else valid = 1'b0;
         @(negedge clk);
         checks++;
         if (writeOp !== rwT[i]) begin
            errors++;
            $display("[TB] FAIL b2b_wop%0d: got %b, expected %b", i, writeOp, rwT[i]);
         end
      end
      cycle();
      @(negedge clk);
      checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b, expected 0", writeOp); end
   endtask

   task automatic test_load_align();
      logic [4:0]  rdT [3];
      logic [2:0]  f3T [3];
      logic [31:0] addrT [3];
      logic [31:0] expT [3];
      rdT = '{5'd10, 5'd11, 5'd12};
      f3T = '{3'b000, 3'b100, 3'b101};
      addrT = '{32'h1003, 32'h1003, 32'h1002};
      expT = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
      for (int i = 0; i < 3; i++) begin
         cycle();
         setLoad(rdT[i], f3T[i], addrT[i]);
         expQ.push_back('{rd: rdT[i], data: expT[i]});
         cycle();
         valid = 1'b0;
         @(negedge clk);
         checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL align_wait%0d: got %b, expected 0", i, writeOp); end
         cycle();
         memValid = 1'b1;
         memData  = 32'h80FF_0000;
         @(negedge clk);
         checks++; if (writeOp !== FWD) begin errors++; $display("[TB] FAIL align_resp%0d: got %b, expected %b", i, writeOp, FWD); end
         cycle();
         memValid = 1'b0;
         @(negedge clk);
         checks++; if (writeOp !== !FWD) begin errors++; $display("[TB] FAIL align_after%0d: got %b, expected %b", i, writeOp, !FWD); end
      end
   endtask

   task automatic test_load_then_alu();
      logic expW [5];
      expW = '{FWD, 1'b1, 1'b1, !FWD, 1'b0};
      cycle();
      setLoad(5'd5, 3'b010, 32'h2000);
      expQ.push_back('{rd: 5'd5, data: 32'h1234_5678});
      expQ.push_back('{rd: 5'd6, data: 32'h66});
      expQ.push_back('{rd: 5'd7, data: 32'h77});
      cycle();
      setAlu(5'd6, 32'h66, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL order_hold0: got %b, expected 0", writeOp); end
      cycle();
      setAlu(5'd7, 32'h77, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL order_hold1: got %b, expected 0", writeOp); end
      cycle();
      valid = 1'b0;
      @(negedge clk);
      checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL order_hold2: got %b, expected 0", writeOp); end
      cycle();
      memValid = 1'b1;
      memData  = 32'h1234_5678;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (writeOp !== expW[k]) begin
            errors++;
            $display("[TB] FAIL order_wop%0d: got %b, expected %b", k, writeOp, expW[k]);
         end
         cycle();
         memValid = 1'b0;
      end
   endtask

   task automatic test_full_stall();
      for (int i = 0; i < 4; i++) begin
         setLoad(5'(8 + i), 3'b100, 32'h0);
         expQ.push_back('{rd: 5'(8 + i), data: 32'(i + 1)});
         cycle();
      end
      valid = 1'b0;
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b, expected 0", ready); end
      cycle();
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL full_stall: got %b, expected 0", ready); end
      cycle();
      memValid = 1'b1;
      memData  = 32'h1;
      cycle();
      memValid = 1'b0;
      @(negedge clk);
      checks++; if (ready !== FWD) begin errors++; $display("[TB] FAIL full_release0: got %b, expected %b", ready, FWD); end
      cycle();
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL full_release1: got %b, expected 1", ready); end
      for (int j = 2; j <= 4; j++) begin
         cycle();
         memValid = 1'b1;
         memData  = 32'(j);
      end
      cycle();
      memValid = 1'b0;
      cycle();
      cycle();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_drain: got %b, expected 0", busy); end
   endtask

   task automatic test_flush();
      cycle();
      setAlu(5'd20, 32'hAB, 32'h0, 1'b0, 1'b1);
      cycle();
      flush = 1'b1;
      setAlu(5'd21, 32'hCD, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL flush_suppress: got %b, expected 0", writeOp); end
      cycle();
      flush = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_enq_ignored: got busy %b, expected 0", busy); end
      setLoad(5'd12, 3'b100, 32'h0);
      cycle();
      setLoad(5'd13, 3'b100, 32'h0);
      cycle();
      valid = 1'b0;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_drop_busy: got %b, expected 1", busy); end
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready: got %b, expected 1", ready); end
      setLoad(5'd14, 3'b100, 32'h1);
      expQ.push_back('{rd: 5'd14, data: 32'hC5});
      cycle();
      valid    = 1'b0;
      memValid = 1'b1;
      memData  = 32'h0000_AA00;
      @(negedge clk);
      checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL drop_a: got %b, expected 0", writeOp); end
      cycle();
      memData = 32'h0000_BB00;
      @(negedge clk);
      checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL drop_b: got %b, expected 0", writeOp); end
      cycle();
      memData = 32'h0000_C500;
      @(negedge clk);
      checks++; if (writeOp !== FWD) begin errors++; $display("[TB] FAIL resp_c: got %b, expected %b", writeOp, FWD); end
      cycle();
      memValid = 1'b0;
      @(negedge clk);
      checks++; if (writeOp !== !FWD) begin errors++; $display("[TB] FAIL resp_c_after: got %b, expected %b", writeOp, !FWD); end
      cycle();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: got %b, expected 0", busy); end
   endtask

   task automatic test_xlen64();
      logic [2:0]  f3T [3];
      logic [63:0] addrT [3];
      logic [63:0] expT [3];
      logic        found;
      f3T = '{3'b011, 3'b010, 3'b110};
      addrT = '{64'h0, 64'h0, 64'h4};
      expT = '{64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h0000_0000_8000_0000};
      for (int i = 0; i < 3; i++) begin
         cycle();
         valid64  = 1'b1;
         funct3   = f3T[i];
         alu64    = addrT[i];
         rd       = 5'(24 + i);
         regWrite = 1'b1;
         resSrc   = SRC_MEM;
         cycle();
         valid64    = 1'b0;
         memValid64 = 1'b1;
         memData64  = 64'h8000_0000_0000_0001;
         found      = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!found && writeOp64) begin
               found = 1'b1;
               checks++;
               if (data64 !== expT[i] || rdOut64 !== 5'(24 + i)) begin
                  errors++;
                  $display("[TB] FAIL x64_load%0d: got rd=%0d data=%h, expected rd=%0d data=%h",
                           i, rdOut64, data64, 24 + i, expT[i]);
               end
            end
            cycle();
            memValid64 = 1'b0;
         end
         if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL x64_timeout%0d: got no write, expected data=%h", i, expT[i]);
         end
      end
   endtask

   task automatic test_reset_midwait();
      cycle();
      setLoad(5'd1, 3'b000, 32'h0);
      cycle();
      valid = 1'b0;
      cycle();
      #2;
      rstN = 1'b0;
      #1;
      checks++; if (writeOp !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_wop: got %b, expected 0", writeOp); end
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b, expected 1", ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b, expected 0", busy); end
      cycle();
      rstN = 1'b1;
      cycle();
      setAlu(5'd9, 32'h99, 32'h0, 1'b0, 1'b1);
      expQ.push_back('{rd: 5'd9, data: 32'h99});
      cycle();
      valid = 1'b0;
      @(negedge clk);
      checks++; if (writeOp !== 1'b1) begin errors++; $display("[TB] FAIL rst_after_alu: got %b, expected 1", writeOp); end
      cycle();
   endtask

   initial begin
      $display("[TB] Starting rv_write_q bench (forwarding=%0d)", FWD);
      test_reset();
      test_back_to_back();
      test_load_align();
      test_load_then_alu();
      test_full_stall();
      test_flush();
      test_xlen64();
      test_reset_midwait();
      cycle();
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_leftover: got %0d pending writes, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
